// File: rtl/matmul_pkg.sv
// matmul_pkg: FSM state encodings and index-width helper shared by the host and the multiplier.
package matmul_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    function automatic int idx_w(input int x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/matmul_stream_host_if.sv
// matmul_stream_host_if: element streams and start/done handshake between host and multiplier.
interface matmul_stream_host_if #(
    parameter int DATA_WIDTH = 16,
    parameter int M = 64,
    parameter int N = 64,
    parameter int K = 64
) ();

    logic                               mm_start;
    logic                               mm_done;
    logic [DATA_WIDTH-1:0]              a_data;
    logic [matmul_pkg::idx_w(M)-1:0]    a_row;
    logic [matmul_pkg::idx_w(K)-1:0]    a_col;
    logic                               a_valid;
    logic [DATA_WIDTH-1:0]              b_data;
    logic [matmul_pkg::idx_w(K)-1:0]    b_row;
    logic [matmul_pkg::idx_w(N)-1:0]    b_col;
    logic                               b_valid;
    logic [DATA_WIDTH-1:0]              c_data;
    logic [matmul_pkg::idx_w(M)-1:0]    c_row;
    logic [matmul_pkg::idx_w(N)-1:0]    c_col;
    logic                               c_valid;

    modport master (
        output mm_start, a_data, a_row, a_col, a_valid, b_data, b_row, b_col, b_valid,
        input  c_data, c_row, c_col, c_valid, mm_done
    );

    modport slave (
        input  mm_start, a_data, a_row, a_col, a_valid, b_data, b_row, b_col, b_valid,
        output c_data, c_row, c_col, c_valid, mm_done
    );

endinterface

// File: rtl/matmul_elem_streamer.sv
// matmul_elem_streamer: row-major RAM reader emitting one tagged element per cycle.
// Tags are registered so they line up with the 1-cycle RAM read data.
module matmul_elem_streamer
    import matmul_pkg::*;
#(
    parameter int ROWS = 64,
    parameter int COLS = 64,
    parameter int DATA_WIDTH = 16,
    localparam int AW = idx_w(ROWS * COLS),
    localparam int RW = idx_w(ROWS),
    localparam int CLW = idx_w(COLS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  run,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic [RW-1:0]         row,
    output logic [CLW-1:0]        col,
    output logic                  valid,
    output logic                  fin
);

    localparam int CW = $clog2(ROWS * COLS) + 1;
    localparam logic [CW-1:0] TOT = CW'(ROWS * COLS);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  row_q, row_d, tag_row_q, tag_row_d;
    logic [CLW-1:0] col_q, col_d, tag_col_q, tag_col_d;
    logic           valid_q, valid_d;
    logic           last_col;

    always_comb begin
        rd_en     = run && (cnt_q != TOT);
        last_col  = col_q == CLW'(COLS - 1);
        cnt_d     = clr ? '0 : cnt_q + CW'(rd_en);
        col_d     = (clr || (rd_en && last_col)) ? '0 : col_q + CLW'(rd_en);
        row_d     = clr ? '0 : row_q + RW'(rd_en && last_col);
        valid_d   = rd_en;
        tag_row_d = rd_en ? row_q : tag_row_q;
        tag_col_d = rd_en ? col_q : tag_col_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            tag_row_q <= '0;
            tag_col_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tag_row_q <= tag_row_d;
            tag_col_q <= tag_col_d;
            valid_q   <= valid_d;
        end
    end

    // RAM data is already aligned with valid_q; gating keeps the bus quiet between elements.
    assign rd_addr = cnt_q[AW-1:0];
    assign data    = valid_q ? rd_data : '0;
    assign row     = tag_row_q;
    assign col     = tag_col_q;
    assign valid   = valid_q;
    assign fin     = cnt_q == TOT;

endmodule

// File: rtl/matmul_stream_host.sv
// matmul_stream_host: streams A and B to the multiplier and captures the C stream into RAM.
// Owns the run FSM, C-order checking and the sticky protocol error flag.
module matmul_stream_host
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M = 64,
    parameter int N = 64,
    parameter int K = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     a_rd_en,
    output logic [idx_w(M*K)-1:0]    a_rd_addr,
    input  logic [DATA_WIDTH-1:0]    a_rd_data,
    output logic                     b_rd_en,
    output logic [idx_w(K*N)-1:0]    b_rd_addr,
    input  logic [DATA_WIDTH-1:0]    b_rd_data,
    output logic                     c_wr_en,
    output logic [idx_w(M*N)-1:0]    c_wr_addr,
    output logic [DATA_WIDTH-1:0]    c_wr_data,
    matmul_stream_host_if.master     mm
);

    localparam int CT  = M * N;
    localparam int CCW = $clog2(CT) + 1;
    localparam int CAW = idx_w(CT);
    localparam int RW  = idx_w(M);
    localparam int CW  = idx_w(N);

    logic [2:0]            state_q, state_d;
    logic [RW-1:0]         exp_row_q, exp_row_d;
    logic [CW-1:0]         exp_col_q, exp_col_d;
    logic [CCW-1:0]        rcv_q, rcv_d;
    logic                  wr_en_q, wr_en_d;
    logic [CAW-1:0]        wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept, in_drain, take, tag_ok, exp_last_col, finish, short_cnt;
    logic                  a_fin, b_fin, clr, run;

    assign clr = state_q == START;
    // Reads launch in GAP so the first element reaches the stream one cycle later.
    assign run = (state_q == GAP) || (state_q == STREAM);

    matmul_elem_streamer #(.ROWS(M), .COLS(K), .DATA_WIDTH(DATA_WIDTH)) u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .run     (run),
        .rd_en   (a_rd_en),
        .rd_addr (a_rd_addr),
        .rd_data (a_rd_data),
        .data    (mm.a_data),
        .row     (mm.a_row),
        .col     (mm.a_col),
        .valid   (mm.a_valid),
        .fin     (a_fin)
    );

    matmul_elem_streamer #(.ROWS(K), .COLS(N), .DATA_WIDTH(DATA_WIDTH)) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .run     (run),
        .rd_en   (b_rd_en),
        .rd_addr (b_rd_addr),
        .rd_data (b_rd_data),
        .data    (mm.b_data),
        .row     (mm.b_row),
        .col     (mm.b_col),
        .valid   (mm.b_valid),
        .fin     (b_fin)
    );

    always_comb begin
        accept       = (state_q == IDLE) && go;
        in_drain     = state_q == DRAIN;
        take         = in_drain && mm.c_valid;
        tag_ok       = (mm.c_row == exp_row_q) && (mm.c_col == exp_col_q);
        exp_last_col = exp_col_q == CW'(N - 1);
        finish       = in_drain && mm.mm_done;
        short_cnt    = (rcv_q + CCW'(take)) != CCW'(CT);
        state_d      = accept ? START
                     : (state_q == START) ? GAP
                     : (state_q == GAP) ? STREAM
                     : (state_q == STREAM && a_fin && b_fin) ? DRAIN
                     : finish ? IDLE
                     : state_q;
        exp_col_d    = (accept || (take && exp_last_col)) ? '0 : exp_col_q + CW'(take);
        exp_row_d    = accept ? '0 : exp_row_q + RW'(take && exp_last_col);
        rcv_d        = accept ? '0 : rcv_q + CCW'(take);
        wr_en_d      = take;
        wr_addr_d    = take ? CAW'(int'(mm.c_row) * N + int'(mm.c_col)) : '0;
        wr_data_d    = take ? mm.c_data : '0;
        done_d       = finish;
        err_d        = accept ? 1'b0
                     : err_q || (take && !tag_ok) || (mm.c_valid && !in_drain) || (finish && short_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            exp_row_q <= '0;
            exp_col_q <= '0;
            rcv_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_row_q <= exp_row_d;
            exp_col_q <= exp_col_d;
            rcv_q     <= rcv_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign err         = err_q;
    assign mm.mm_start = state_q == START;
    assign c_wr_en     = wr_en_q;
    assign c_wr_addr   = wr_addr_q;
    assign c_wr_data   = wr_data_q;

endmodule
